// File: rtl/dfd_apb_req_bridge_if.sv
// Bundled request/response stream and APB master signals for dfd_apb_req_bridge.
// master: bridge side. slave: request source, response sink and APB completer side.
`ifndef DFD_APB_ADDR_WIDTH
`define DFD_APB_ADDR_WIDTH 32
`endif
`ifndef DFD_APB_DATA_WIDTH
`define DFD_APB_DATA_WIDTH 32
`endif
`ifndef DFD_APB_PSTRB_WIDTH
`define DFD_APB_PSTRB_WIDTH 4
`endif

interface dfd_apb_req_bridge_if #(
  parameter int ADDR_WIDTH = `DFD_APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DFD_APB_DATA_WIDTH,
  parameter int STRB_WIDTH = `DFD_APB_PSTRB_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/dfd_apb_req_bridge.sv
// Register-request stream to APB master: 2-entry request FIFO, one transfer in flight,
// in-order responses. Optional ACCESS timeout abort enabled by DFD_APB_BRIDGE_TIMEOUT_EN.
`ifndef DFD_APB_ADDR_WIDTH
`define DFD_APB_ADDR_WIDTH 32
`endif
`ifndef DFD_APB_DATA_WIDTH
`define DFD_APB_DATA_WIDTH 32
`endif
`ifndef DFD_APB_PSTRB_WIDTH
`define DFD_APB_PSTRB_WIDTH 4
`endif

module dfd_apb_req_bridge #(
  parameter int ADDR_WIDTH     = `DFD_APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DFD_APB_DATA_WIDTH,
  parameter int STRB_WIDTH     = `DFD_APB_PSTRB_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dfd_apb_req_bridge_if.master bus,
  output logic                 busy
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  req_t                  fifo_q [2];
  req_t                  fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  req_t                  cur_q, cur_d;
  logic                  psel_q, psel_d, penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  push, bypass, pop;
  req_t                  in_req;

`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cur_d         = cur_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif
    pop    = 1'b0;
    bypass = 1'b0;
    push   = bus.req_valid && (count_q != 2'd2);

    // Reads carry zero strobe/data so the APB bus never shows stale write payload.
    in_req.write = bus.req_write;
    in_req.addr  = bus.req_addr;
    in_req.wdata = bus.req_write ? bus.req_wdata : '0;
    in_req.strb  = bus.req_write ? bus.req_strb  : '0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          cur_d   = fifo_q[rd_ptr_q];
          pop     = 1'b1;
          psel_d  = 1'b1;
          state_d = S_SETUP;
        end else if (push) begin
          // Empty FIFO: the accepted request goes straight to SETUP next cycle.
          cur_d   = in_req;
          bypass  = 1'b1;
          psel_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!cur_q.write && !bus.pslverr) ? bus.prdata : '0;
          state_d       = S_RESP;
        end
`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push && !bypass) begin
      fifo_d[wr_ptr_q] = in_req;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    count_d = count_q + {1'b0, push && !bypass} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      cur_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cur_q         <= cur_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign bus.req_ready   = (count_q != 2'd2);
  assign bus.paddr       = cur_q.addr;
  assign bus.pwrite      = cur_q.write;
  assign bus.pwdata      = cur_q.wdata;
  assign bus.pstrb       = cur_q.strb;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign busy            = (count_q != 2'd0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_dfd_apb_req_bridge.sv
// Bench for dfd_apb_req_bridge: directed latency/ordering/error/reset cases plus a random
// soak, checked against a memory-level reference model with an in-order expectation queue.
`timescale 1ns/1ps
module tb_dfd_apb_req_bridge;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  dfd_apb_req_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  dfd_apb_req_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: flat memory, error region 0xExxx, never-ready region 0xDxxx.
  typedef struct { logic [DW-1:0] rdata; logic err; logic tmo; } exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction
  function automatic logic is_err(input logic [AW-1:0] a);
    return a[15:12] == 4'hE;
  endfunction
  function automatic logic is_hang(input logic [AW-1:0] a);
    return a[15:12] == 4'hD;
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int unsigned b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] rd_dev(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction
  function automatic logic [AW-1:0] rand_addr(input bit allow_err);
    logic [3:0] rgn = 4'($urandom_range(1, 3));
    if (allow_err && $urandom_range(0, 4) == 0) rgn = 4'hE;
    return {16'h0, rgn, 4'h0, 5'($urandom_range(0, 31)), 3'b000};
  endfunction

  // APB completer: configurable wait states, pslverr noise while not ready.
  int   slv_waits = 0;
  bit   slv_rand = 0;
  bit   late_pready = 0;
  int   sw_left = 0;
  logic [104:0] snap;
  always @(negedge clk) begin
    #1;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = {$urandom, $urandom};
    if (reset_n && !bus.psel && late_pready) bus.pready = 1'b1;
    if (reset_n && bus.psel) begin
      if (!bus.penable) begin
        sw_left = slv_rand ? int'($urandom_range(0, 3)) : slv_waits;
        snap = {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb};
        if (!bus.pwrite) chk("apb_rd_zero", {bus.pstrb, bus.pwdata}, '0);
      end else begin
        chk("apb_stable", {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb}, snap);
        if (is_hang(bus.paddr) || sw_left > 0) begin
          sw_left--;
          bus.pslverr = 1'b1;
        end else begin
          bus.pready  = 1'b1;
          bus.pslverr = is_err(bus.paddr);
          if (!is_err(bus.paddr)) begin
            if (bus.pwrite) dev_mem[bus.paddr] = merge(rd_dev(bus.paddr), bus.pwdata, bus.pstrb);
            else bus.prdata = rd_dev(bus.paddr);
          end
        end
      end
    end
  end

  // Monitor: predicts at acceptance, checks at response handshake, checks hold under backpressure.
  int   rsp_seen = 0;
  exp_t mon_e;
  logic hold_pend = 1'b0;
  logic [66:0] hold_val;
  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("rsp_hold", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, hold_val);
      hold_pend = bus.rsp_valid && !bus.rsp_ready;
      hold_val  = {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
      if (bus.req_valid && bus.req_ready) begin
        mon_e.rdata = '0; mon_e.err = 1'b0; mon_e.tmo = 1'b0;
        if (is_hang(bus.req_addr)) begin
          mon_e.err = 1'b1; mon_e.tmo = 1'b1;
        end else if (is_err(bus.req_addr)) mon_e.err = 1'b1;
        else if (bus.req_write)
          ref_mem[bus.req_addr] = merge(rd_ref(bus.req_addr), bus.req_wdata, bus.req_strb);
        else mon_e.rdata = rd_ref(bus.req_addr);
        exp_q.push_back(mon_e);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_seen++;
        chk("rsp_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
          chk("rsp_err", bus.rsp_err, mon_e.err);
          chk("rsp_timeout", bus.rsp_timeout, mon_e.tmo);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int waited);
    waited = 0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = d; bus.req_strb = s;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) chk("push_accept", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int c = 0;
    while (!bus.rsp_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(tag, bus.rsp_valid, 1);
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic reset_pulse();
    int seen;
    #3 reset_n = 1'b0;
    #1;
    chk("rstp_psel", bus.psel, 0);
    chk("rstp_penable", bus.penable, 0);
    chk("rstp_paddr", bus.paddr, '0);
    chk("rstp_rsp_valid", bus.rsp_valid, 0);
    chk("rstp_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    chk("rstp_req_ready", bus.req_ready, 1);
    seen = rsp_seen;
    repeat (6) tick();
    chk("rstp_no_rsp", rsp_seen, seen);
    chk("rstp_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int w, n, target;
  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, '0);
    chk("rst_pwdata", {bus.pwrite, bus.pstrb, bus.pwdata}, '0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, '0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_req_ready", bus.req_ready, 1);

    // Zero-wait read: SETUP T+1, ACCESS T+2, response T+3.
    dev_mem[32'h100] = 64'hCEED1020;
    ref_mem[32'h100] = 64'hCEED1020;
    bus.rsp_ready = 1'b1;
    push_req(1'b0, 32'h100, '1, '1, w);
    chk("t1_accept_wait", w, 0);
    chk("t1_setup", {bus.psel, bus.penable, bus.paddr}, {2'b10, 32'h100});
    tick();
    chk("t1_access", {bus.psel, bus.penable}, 2'b11);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rdata", bus.rsp_rdata, 64'hCEED1020);
    chk("t1_err", bus.rsp_err, 0);
    tick();
    chk("t1_done", {bus.rsp_valid, busy}, 2'b00);

    // Write with 3 wait states: 5 stable bus cycles, response at T+6.
    slv_waits = 3;
    push_req(1'b1, 32'h200, 64'hA5A5, 8'hFF, w);
    for (int i = 0; i < 5; i++) begin
      chk("t2_psel", bus.psel, 1);
      chk("t2_penable", bus.penable, i != 0);
      chk("t2_paddr", bus.paddr, 32'h200);
      chk("t2_pwdata", bus.pwdata, 64'hA5A5);
      tick();
    end
    chk("t2_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 64'h0});
    tick();

    // Three back-to-back pushes under response backpressure.
    slv_waits = 0;
    bus.rsp_ready = 1'b0;
    target = rsp_seen + 3;
    for (int i = 0; i < 3; i++) begin
      push_req(1'($urandom_range(0, 1)), rand_addr(1'b1), {$urandom, $urandom}, 8'($urandom), w);
      chk("t3_push_wait", w, 0);
    end
    chk("t3_full", bus.req_ready, 0);
    repeat (4) begin
      tick();
      chk("t3_full_hold", {bus.req_ready, bus.rsp_valid}, 2'b01);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t3_gap_idle", bus.psel, 0);
    tick();
    chk("t3_next_setup", {bus.psel, bus.penable}, 2'b10);
    drain("t3_drain");
    chk("t3_rsp_count", rsp_seen, target);

    // PSLVERR on completion vs. pslverr noise during wait states.
    slv_waits = 2;
    push_req(1'b0, 32'h0000_E040, '0, '0, w);
    wait_rsp("t4_err_wait");
    chk("t4_err", {bus.rsp_err, bus.rsp_rdata}, {1'b1, 64'h0});
    tick();
    push_req(1'b0, 32'h0000_1040, '0, '0, w);
    wait_rsp("t4_ok_wait");
    chk("t4_noise_err", bus.rsp_err, 0);
    chk("t4_noise_rdata", bus.rsp_rdata, rd_ref(32'h0000_1040));
    tick();

`ifdef DFD_APB_BRIDGE_TIMEOUT_EN
    // Never-ready completer: abort after TO ACCESS cycles, late pready ignored, next request runs.
    slv_waits = 0;
    bus.rsp_ready = 1'b0;
    late_pready = 1'b1;
    push_req(1'b0, 32'h0000_D010, '0, '0, w);
    push_req(1'b0, 32'h0000_2018, '0, '0, w);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!(bus.psel && bus.penable)) break;
      n++;
      tick();
    end
    chk("t5_access_cycles", n, TO);
    chk("t5_abort", {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
        {4'b0111, 64'h0});
    repeat (3) tick();
    chk("t5_late_pready", {bus.rsp_valid, bus.rsp_timeout}, 2'b11);
    late_pready = 1'b0;
    bus.rsp_ready = 1'b1;
    drain("t5_drain");

    // Reset during ACCESS.
    slv_waits = 6;
    push_req(1'b0, 32'h0000_1080, '0, '0, w);
    tick();
    chk("t6_in_access", {bus.psel, bus.penable}, 2'b11);
    reset_pulse();
`else
    // No timeout: ACCESS waits indefinitely; then reset while stuck there.
    slv_waits = 0;
    push_req(1'b0, 32'h0000_D010, '0, '0, w);
    repeat (20) tick();
    chk("t5_still_access", {bus.psel, bus.penable, bus.rsp_valid}, 3'b110);
    chk("t5_no_timeout", bus.rsp_timeout, 0);
    reset_pulse();
`endif

    // Random soak: random ops, addresses, strobes, wait states and rsp_ready.
    slv_rand = 1'b1;
    target = rsp_seen + 150;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_req(1'($urandom_range(0, 1)), rand_addr(1'b1), {$urandom, $urandom}, 8'($urandom), w);
        end
      end
      begin
        for (int c = 0; c < 6000 && rsp_seen < target; c++) begin
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    bus.rsp_ready = 1'b1;
    drain("soak_drain");
    chk("soak_rsp_count", rsp_seen, target);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dfd_apb_req_bridge.md
# dfd_apb_req_bridge

- Converts a valid/ready register-request stream into APB master transactions and returns one response per request.
- Sits directly upstream of `dfd_mmrs` and drives its `paddr`/`psel`/`penable`/`pwrite`/`pstrb`/`pwdata` inputs. The request source is the debug transport (DMI or JTAG side).
- Buffers up to two requests, keeps at most one APB transfer outstanding, and returns read data with error status.

## Interface
Parameters:
- `ADDR_WIDTH`, default `DFD_APB_ADDR_WIDTH`: APB address width.
- `DATA_WIDTH`, default `DFD_APB_DATA_WIDTH`: APB data width.
- `STRB_WIDTH`, default `DFD_APB_PSTRB_WIDTH`: byte-strobe width (`DATA_WIDTH/8`).
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS cycles before abort. Used only with `DFD_APB_BRIDGE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, shared with `dfd_mmrs`.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH / `req_wdata` in DATA_WIDTH / `req_strb` in STRB_WIDTH: request fields.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_err` out 1: PSLVERR or timeout.
- `rsp_timeout` out 1: timeout abort.
- `paddr`, `psel`, `penable`, `pwrite`, `pstrb`, `pwdata` out: APB master request.
- `pready`, `prdata`, `pslverr` in: APB completion.
- `busy` out 1: FIFO non-empty or FSM not IDLE.

## Operation
Request FIFO:
- 2 entries. `req_ready = !full`.
- Push on `req_valid && req_ready`; pop when the FSM leaves IDLE.

FSM states:
- IDLE: if the FIFO is non-empty, pop the head, latch its fields, go to SETUP.
- SETUP: `psel=1`, `penable=0`; the latched fields are driven on APB. Go to ACCESS next cycle.
- ACCESS: `psel=1`, `penable=1`.
  - On `pready=1`: capture `prdata` if the request is a read and `pslverr=0`; capture `pslverr`; go to RESP.
  - `pslverr` is ignored while `pready=0`.
- RESP: `rsp_valid=1`, `psel=0`, `penable=0`. On `rsp_ready`, go to IDLE.

Data and ordering rules:
- `paddr`/`pwrite`/`pstrb`/`pwdata` stay stable from SETUP through the last ACCESS cycle.
- Reads drive `pstrb=0`, `pwdata=0`.
- On `pslverr=1`: `rsp_err=1` and `rsp_rdata=0`.
- Responses are returned strictly in request order, one per request, including writes.

## Timing
Reset:
- All outputs 0; FIFO empty; FSM in IDLE.
- Because FIFO is empty after reset, `req_ready` = 1 after reset.
- Reset asserted mid-transfer drops `psel`/`penable` asynchronously and discards FIFO and response state. No response is produced for in-flight requests.

Latency:
- Request accepted at cycle T with FSM in IDLE and FIFO empty: SETUP at T+1, ACCESS at T+2.
- `pready` at T+2 gives `rsp_valid` at T+3. Minimum latency is 3 cycles.
- Each wait state adds 1 cycle.

Back-to-back and backpressure:
- Response handshake at cycle R with FIFO non-empty: next SETUP at R+2 (IDLE at R+1). No bus-idle overlap.
- `rsp_valid` and the response fields hold until `rsp_ready`. The FIFO keeps accepting until full.

Boundary conditions:
- Push while full is not allowed (`req_ready=0`).
- A simultaneous push and pop at full is not allowed: pop happens only in IDLE, and `req_ready` reflects full before that pop.

## Configuration
Macro `DFD_APB_BRIDGE_TIMEOUT_EN`.

With the macro defined:
- A counter clears on SETUP and increments each ACCESS cycle with `pready=0`.
- When the counter reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`, and deasserts `psel`/`penable`.
- A late `pready` arriving after the abort is ignored.

Without the macro:
- No counter is built. ACCESS waits indefinitely.
- `rsp_timeout` is tied to 0.

## Test plan
- Read `0x100` with zero wait states and `prdata=0xCEED1020`:
  - `psel` rises at T+1, `penable` at T+2.
  - At T+3: `rsp_valid`, `rsp_rdata=0xCEED1020`, `rsp_err=0`.
- Write `0x200` data `0xA5A5` strb `0xFF` with 3 wait states:
  - `paddr`/`pwdata` are stable for 5 bus cycles.
  - `rsp_valid` at T+6 with `rsp_err=0`.
- Three requests pushed back-to-back with `rsp_ready=0`:
  - `req_ready` drops after the third push (2 in FIFO plus 1 latched).
  - Releasing `rsp_ready` yields 3 in-order responses.
- Read with `pready=1`, `pslverr=1`: `rsp_err=1`, `rsp_rdata=0`. Also check that `pslverr=1` with `pready=0` has no effect.
- With the macro and `TIMEOUT_CYCLES=8`, `pready` held at 0:
  - Abort after 8 ACCESS cycles with `rsp_err=1`, `rsp_timeout=1`.
  - The next queued request proceeds normally.
- `reset_n` pulsed low during ACCESS: all outputs 0 immediately, no response emitted, and `req_ready=1` after release.
